x_top_mem_link: RTL and testbench
=================================

X_TOP_MEM_LINK -- requirements
Module: x_top_mem_link

Interface
REQ-001 SHALL have parameter p_clk_hz, default 1000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter p_baud, default 9600, meaning UART bit rate.
REQ-003 SHALL have parameter p_addr_bytes, default 4, legal range 1-4, meaning address bytes sent per transaction.
REQ-004 SHALL have parameter p_data_bytes, default 4, legal range 1-4, meaning data bytes per transaction.
REQ-005 SHALL have parameter p_timeout, default 100000, meaning the clock-cycle limit per awaited rx byte.
REQ-006 SHALL have port i_clk, input, 1, the single clock.
REQ-007 SHALL have port i_nrst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_rnw, input, 1, 1 = read, 0 = write.
REQ-009 SHALL have port i_valid, input, 1, request valid.
REQ-010 SHALL have port o_accept, output, 1, one-cycle transaction-complete pulse.
REQ-011 SHALL have port i_addr, input, 8*p_addr_bytes, request address.
REQ-012 SHALL have port i_data, input, 8*p_data_bytes, write data.
REQ-013 SHALL have port i_be, input, p_data_bytes, byte enables.
REQ-014 SHALL have port o_data, output, 8*p_data_bytes, read data, valid with o_accept.
REQ-015 SHALL have port o_err, output, 1, error status, valid with o_accept.
REQ-016 SHALL have port i_rx, input, 1, UART receive line.
REQ-017 SHALL have port o_tx, output, 1, UART transmit line.

Function
REQ-018 SHALL use states IDLE, TX_CMD, TX_ADDR, TX_DATA, RX_DATA, RX_ACK, DONE, with a byte index counter inside the multi-byte states.
REQ-019 SHALL leave IDLE for TX_CMD on the cycle after i_valid=1 is sampled; requester holds i_rnw/i_addr/i_data/i_be stable until o_accept.
REQ-020 SHALL send a command byte with bit7=i_rnw, bits6:4=0 and bits3:0=i_be zero-extended.
REQ-021 SHALL send p_addr_bytes address bytes LSB first, then for writes p_data_bytes i_data bytes LSB first, regardless of i_be.
REQ-022 SHALL hold UART tx valid high in every TX_* state and advance one byte per tx accept.
REQ-023 SHALL, on a read, collect p_data_bytes rx bytes LSB first into o_data, then enter DONE.
REQ-024 SHALL, on a write, wait in RX_ACK for one byte; 0xA5 gives o_err=0, any other value gives o_err=1; then enter DONE.
REQ-025 SHALL pulse o_accept for exactly one cycle in DONE, then return to IDLE; the next i_valid is sampled from IDLE only.
REQ-026 SHALL run a timeout counter of width $clog2(p_timeout+1) in RX_DATA/RX_ACK, clearing on each rx byte and on state entry.
REQ-027 SHALL, when the timeout counter reaches p_timeout-1, enter DONE with o_err=1 and o_data=0.
REQ-028 SHALL give an rx byte priority over timeout expiry when both occur in the same cycle.
REQ-029 SHALL discard rx bytes arriving in any TX_*, IDLE or DONE state.
REQ-030 SHALL hold o_data and o_err until the next DONE.

Reset
REQ-031 SHALL, while i_nrst=0 (including mid-transaction), force state=IDLE, o_accept=0, o_err=0, o_data=0, timeout=0, index=0 and o_tx=1.
REQ-032 SHALL abandon a partial UART frame on reset, with no completion reported.

Structure
REQ-033 SHALL place the state enum, command bit positions and the ACK_OK constant (8'hA5) in shared package x_top_mem_pkg.
REQ-034 SHALL instantiate the existing x_top_uart_tx and x_top_uart_rx sub-modules, with no other sub-module.

Verification
REQ-035 SHALL cover, with p_clk_hz=1000000, p_baud=100000 and defaults: a read at addr 0x12345678, be 0xF -> tx bytes 0x8F,78,56,34,12; rx 0xEF,BE,AD,DE -> o_data=0xDEADBEEF, o_err=0, one o_accept.
REQ-036 SHALL cover a write of 0xCAFEF00D, be 0x3, addr 0x10 -> tx 0x03,10,00,00,00,0D,F0,FE,CA; ack 0xA5 -> o_err=0.
REQ-037 SHALL cover a write acked with 0x5A -> o_accept with o_err=1.
REQ-038 SHALL cover a read with p_timeout=2000 and only 2 rx bytes -> o_accept 2000 cycles after the last byte, o_err=1, o_data=0.
REQ-039 SHALL cover p_addr_bytes=2, p_data_bytes=1 read -> 3 tx bytes and 1 rx byte -> o_data 8 bits.
REQ-040 SHALL cover i_nrst pulsed mid-TX_ADDR -> o_tx=1, no o_accept, and the next request completes normally.

Source files
------------

// File: rtl/x_top_mem_pkg.sv
// ---------------------------------------------------------------------------
// x_top_mem_pkg
// Shared definitions for the UART memory link: controller state encoding,
// command byte layout, the write-acknowledge code and a command-byte builder.
// ---------------------------------------------------------------------------
package x_top_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX_CMD  = 3'd1,
        ST_TX_ADDR = 3'd2,
        ST_TX_DATA = 3'd3,
        ST_RX_DATA = 3'd4,
        ST_RX_ACK  = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Command byte layout: bit7 = read/not-write, bits3:0 = byte enables
    localparam int CMD_RNW_BIT = 7;
    localparam int CMD_BE_LSB  = 0;
    localparam int CMD_BE_W    = 4;

    // Reply byte that marks a successful write
    localparam logic [7:0] ACK_OK = 8'hA5;

    function automatic logic [7:0] make_cmd(input logic rnw, input logic [3:0] be);
        logic [7:0] cmd;
        cmd = 8'h00;
        cmd[CMD_RNW_BIT] = rnw;
        cmd[CMD_BE_LSB +: CMD_BE_W] = be;
        return cmd;
    endfunction

endpackage

// File: rtl/x_top_uart_rx.sv
// ---------------------------------------------------------------------------
// x_top_uart_rx
// 8N1 UART receiver; emits a one-cycle valid pulse per correctly framed byte.
// Ports:
//   i_clk, i_nrst     clock, asynchronous active-low reset
//   i_rx              serial line (asynchronous, synchronised internally)
//   o_valid, o_data   received byte strobe and value
// ---------------------------------------------------------------------------
module x_top_uart_rx #(
    parameter int p_clk_hz = 1000000,
    parameter int p_baud   = 9600
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data
);

    localparam int DIV  = p_clk_hz / p_baud;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);

    logic          sync1_r;
    logic          rx_s_r;
    logic          active_r;
    logic [3:0]    bit_cnt_r;
    logic [CW-1:0] cnt_r;
    logic [7:0]    shift_r;
    logic          valid_r;
    logic [7:0]    data_r;

    // Two-flop synchroniser for the asynchronous line
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sync1_r <= 1'b1;
            rx_s_r  <= 1'b1;
        end else begin
            sync1_r <= i_rx;
            rx_s_r  <= sync1_r;
        end
    end

    // Start detect, mid-bit sampling and stop-bit check
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            active_r  <= 1'b0;
            bit_cnt_r <= 4'd0;
            cnt_r     <= {CW{1'b0}};
            shift_r   <= 8'h00;
            valid_r   <= 1'b0;
            data_r    <= 8'h00;
        end else begin
            valid_r <= 1'b0;
            if (!active_r) begin
                if (!rx_s_r) begin
                    // Half a bit to reach the middle of the start bit
                    active_r  <= 1'b1;
                    cnt_r     <= CW'(HALF);
                    bit_cnt_r <= 4'd0;
                end else begin
                    active_r <= 1'b0;
                end
            end else if (cnt_r == {CW{1'b0}}) begin
                cnt_r <= CW'(DIV - 1);
                if (bit_cnt_r == 4'd0) begin
                    // A start bit that is high again was a glitch
                    if (rx_s_r) begin
                        active_r <= 1'b0;
                    end else begin
                        bit_cnt_r <= 4'd1;
                    end
                end else if (bit_cnt_r == 4'd9) begin
                    active_r <= 1'b0;
                    if (rx_s_r) begin
                        valid_r <= 1'b1;
                        data_r  <= shift_r;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end else begin
                    shift_r   <= {rx_s_r, shift_r[7:1]};
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
            end else begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end

    assign o_valid = valid_r;
    assign o_data  = data_r;

endmodule

// File: rtl/x_top_uart_tx.sv
// ---------------------------------------------------------------------------
// x_top_uart_tx
// 8N1 UART transmitter with a valid/ready byte interface.
// Ports:
//   i_clk, i_nrst     clock, asynchronous active-low reset
//   i_valid, i_data   byte offered for transmission
//   o_ready           high while idle; a byte is taken when valid & ready
//   o_tx              serial line, idles high
// ---------------------------------------------------------------------------
module x_top_uart_tx #(
    parameter int p_clk_hz = 1000000,
    parameter int p_baud   = 9600
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int DIV = p_clk_hz / p_baud;
    localparam int CW  = $clog2(DIV + 1);

    logic          busy_r;
    logic [8:0]    shift_r;
    logic [3:0]    bit_cnt_r;
    logic [CW-1:0] baud_cnt_r;
    logic          tx_r;

    // Frame sequencer: start bit driven on accept, then 8 data bits, then stop
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            busy_r     <= 1'b0;
            shift_r    <= 9'h1FF;
            bit_cnt_r  <= 4'd0;
            baud_cnt_r <= {CW{1'b0}};
            tx_r       <= 1'b1;
        end else if (!busy_r) begin
            if (i_valid) begin
                busy_r     <= 1'b1;
                shift_r    <= {1'b1, i_data};
                bit_cnt_r  <= 4'd0;
                baud_cnt_r <= {CW{1'b0}};
                tx_r       <= 1'b0;
            end else begin
                tx_r <= 1'b1;
            end
        end else if (baud_cnt_r == CW'(DIV - 1)) begin
            baud_cnt_r <= {CW{1'b0}};
            if (bit_cnt_r == 4'd9) begin
                busy_r <= 1'b0;
                tx_r   <= 1'b1;
            end else begin
                // The top bit of shift_r is the stop bit, shifted out last
                tx_r      <= shift_r[0];
                shift_r   <= {1'b1, shift_r[8:1]};
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end
        end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
        end
    end

    assign o_ready = ~busy_r;
    assign o_tx    = tx_r;

endmodule

// File: rtl/x_top_mem_link.sv
// ---------------------------------------------------------------------------
// x_top_mem_link
// Bridges a simple read/write request port onto a UART byte protocol.
// A request sends a command byte, the address bytes and (for writes) the data
// bytes, then waits for read data or a one-byte write acknowledge.
// Ports:
//   i_clk, i_nrst            clock, asynchronous active-low reset
//   i_valid, i_rnw           request strobe and direction (1 = read)
//   i_addr, i_data, i_be     request address, write data, byte enables
//   o_accept                 one-cycle completion pulse
//   o_data, o_err            read data and error flag, valid with o_accept
//   i_rx, o_tx               UART lines
// ---------------------------------------------------------------------------
module x_top_mem_link #(
    parameter int p_clk_hz     = 1000000,
    parameter int p_baud       = 9600,
    parameter int p_addr_bytes = 4,
    parameter int p_data_bytes = 4,
    parameter int p_timeout    = 100000
) (
    input  logic                      i_clk,
    input  logic                      i_nrst,
    input  logic                      i_rnw,
    input  logic                      i_valid,
    output logic                      o_accept,
    input  logic [8*p_addr_bytes-1:0] i_addr,
    input  logic [8*p_data_bytes-1:0] i_data,
    input  logic [p_data_bytes-1:0]   i_be,
    output logic [8*p_data_bytes-1:0] o_data,
    output logic                      o_err,
    input  logic                      i_rx,
    output logic                      o_tx
);

    import x_top_mem_pkg::*;

    localparam int AB = p_addr_bytes;
    localparam int DB = p_data_bytes;
    localparam int TW = $clog2(p_timeout + 1);

    state_t          state_r;
    state_t          next_state_s;
    logic [2:0]      idx_r;
    logic [TW-1:0]   tmo_r;
    logic [8*DB-1:0] rx_buf_r;
    logic            accept_r;
    logic            err_r;
    logic [8*DB-1:0] data_r;

    logic            tx_valid_s;
    logic            tx_ready_s;
    logic [7:0]      tx_byte_s;
    logic            rx_valid_s;
    logic [7:0]      rx_data_s;
    logic [8*AB-1:0] addr_sh_s;
    logic [8*DB-1:0] data_sh_s;
    logic [8*DB+7:0] rd_cat_s;
    logic [8*DB-1:0] rd_next_s;
    logic            tmo_hit_s;
    logic            last_addr_s;
    logic            last_data_s;
    logic [8*DB-1:0] done_data_s;
    logic            done_err_s;

    x_top_uart_tx #(
        .p_clk_hz (p_clk_hz),
        .p_baud   (p_baud)
    ) u_tx (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_valid (tx_valid_s),
        .i_data  (tx_byte_s),
        .o_ready (tx_ready_s),
        .o_tx    (o_tx)
    );

    x_top_uart_rx #(
        .p_clk_hz (p_clk_hz),
        .p_baud   (p_baud)
    ) u_rx (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_rx    (i_rx),
        .o_valid (rx_valid_s),
        .o_data  (rx_data_s)
    );

    assign tmo_hit_s   = (tmo_r == TW'(p_timeout - 1));
    assign last_addr_s = (idx_r == 3'(AB - 1));
    assign last_data_s = (idx_r == 3'(DB - 1));
    // Bytes arrive LSB first, so each new byte enters at the top and the
    // buffer shifts down; after DB bytes byte 0 sits in the low lane.
    assign rd_cat_s    = {rx_data_s, rx_buf_r};
    assign rd_next_s   = rd_cat_s[8*DB+7:8];

    // State register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and selection of the byte offered to the transmitter
    always_comb begin
        next_state_s = state_r;
        tx_valid_s   = 1'b0;
        tx_byte_s    = 8'h00;
        addr_sh_s    = i_addr >> {idx_r, 3'b000};
        data_sh_s    = i_data >> {idx_r, 3'b000};
        case (state_r)
            ST_IDLE: begin
                if (i_valid) begin
                    next_state_s = ST_TX_CMD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_TX_CMD: begin
                tx_valid_s = 1'b1;
                tx_byte_s  = make_cmd(i_rnw, 4'(i_be));
                if (tx_ready_s) begin
                    next_state_s = ST_TX_ADDR;
                end else begin
                    next_state_s = ST_TX_CMD;
                end
            end
            ST_TX_ADDR: begin
                tx_valid_s = 1'b1;
                tx_byte_s  = addr_sh_s[7:0];
                if (tx_ready_s && last_addr_s) begin
                    next_state_s = i_rnw ? ST_RX_DATA : ST_TX_DATA;
                end else begin
                    next_state_s = ST_TX_ADDR;
                end
            end
            ST_TX_DATA: begin
                tx_valid_s = 1'b1;
                tx_byte_s  = data_sh_s[7:0];
                if (tx_ready_s && last_data_s) begin
                    next_state_s = ST_RX_ACK;
                end else begin
                    next_state_s = ST_TX_DATA;
                end
            end
            ST_RX_DATA: begin
                // A byte arriving on the expiry cycle still counts
                if (rx_valid_s) begin
                    next_state_s = last_data_s ? ST_DONE : ST_RX_DATA;
                end else if (tmo_hit_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RX_DATA;
                end
            end
            ST_RX_ACK: begin
                if (rx_valid_s || tmo_hit_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RX_ACK;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Result captured on the transition into DONE (timeout unless a byte ended it)
    always_comb begin
        done_data_s = {(8*DB){1'b0}};
        done_err_s  = 1'b1;
        case (state_r)
            ST_RX_DATA: begin
                if (rx_valid_s) begin
                    done_data_s = rd_next_s;
                    done_err_s  = 1'b0;
                end else begin
                    done_err_s  = 1'b1;
                end
            end
            ST_RX_ACK: begin
                if (rx_valid_s) begin
                    done_err_s = (rx_data_s != ACK_OK);
                end else begin
                    done_err_s = 1'b1;
                end
            end
            default: begin
                done_err_s = 1'b1;
            end
        endcase
    end

    // Byte index, reply timeout counter and read-data collection
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            idx_r    <= 3'd0;
            tmo_r    <= {TW{1'b0}};
            rx_buf_r <= {(8*DB){1'b0}};
        end else begin
            if (next_state_s != state_r) begin
                idx_r <= 3'd0;
            end else if ((tx_valid_s && tx_ready_s) ||
                         (state_r == ST_RX_DATA && rx_valid_s)) begin
                idx_r <= idx_r + 3'd1;
            end else begin
                idx_r <= idx_r;
            end

            // Counts only while waiting and nothing arrived; any other case clears
            if ((state_r == ST_RX_DATA || state_r == ST_RX_ACK) &&
                next_state_s == state_r && !rx_valid_s) begin
                tmo_r <= tmo_r + TW'(1);
            end else begin
                tmo_r <= {TW{1'b0}};
            end

            if (state_r == ST_RX_DATA && rx_valid_s) begin
                rx_buf_r <= rd_next_s;
            end else if (next_state_s == ST_RX_DATA && state_r != ST_RX_DATA) begin
                rx_buf_r <= {(8*DB){1'b0}};
            end else begin
                rx_buf_r <= rx_buf_r;
            end
        end
    end

    // Completion pulse and result registers held until the next completion
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            accept_r <= 1'b0;
            err_r    <= 1'b0;
            data_r   <= {(8*DB){1'b0}};
        end else begin
            accept_r <= (next_state_s == ST_DONE);
            if (next_state_s == ST_DONE && state_r != ST_DONE) begin
                data_r <= done_data_s;
                err_r  <= done_err_s;
            end else begin
                data_r <= data_r;
                err_r  <= err_r;
            end
        end
    end

    assign o_accept = accept_r;
    assign o_err    = err_r;
    assign o_data   = data_r;

endmodule

// File: tb/tb_x_top_mem_link.sv
// ---------------------------------------------------------------------------
// tb_x_top_mem_link
// Three link instances share clock, reset and the rx line: dut_a (4/4 bytes,
// default timeout), dut_b (2 address bytes, 1 data byte) and dut_t (4/4 bytes,
// timeout 2000). A monitor decodes the selected instance's tx line into got_q.
// ---------------------------------------------------------------------------
module tb_x_top_mem_link;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic rx_line = 1'b1;

    logic        rnw_a = 1'b0, valid_a = 1'b0;
    logic [31:0] addr_a = 32'h0, data_a = 32'h0;
    logic [3:0]  be_a = 4'h0;
    logic        accept_a, err_a, tx_a;
    logic [31:0] rdata_a;

    logic        rnw_b = 1'b0, valid_b = 1'b0;
    logic [15:0] addr_b = 16'h0;
    logic [7:0]  data_b = 8'h0;
    logic [0:0]  be_b = 1'b0;
    logic        accept_b, err_b, tx_b;
    logic [7:0]  rdata_b;

    logic        rnw_t = 1'b0, valid_t = 1'b0;
    logic [31:0] addr_t = 32'h0, data_t = 32'h0;
    logic [3:0]  be_t = 4'h0;
    logic        accept_t, err_t, tx_t;
    logic [31:0] rdata_t;

    x_top_mem_link #(.p_clk_hz(1000000), .p_baud(100000)) dut_a (
        .i_clk(clk), .i_nrst(rst_n), .i_rnw(rnw_a), .i_valid(valid_a),
        .o_accept(accept_a), .i_addr(addr_a), .i_data(data_a), .i_be(be_a),
        .o_data(rdata_a), .o_err(err_a), .i_rx(rx_line), .o_tx(tx_a));

    x_top_mem_link #(.p_clk_hz(1000000), .p_baud(100000),
                     .p_addr_bytes(2), .p_data_bytes(1)) dut_b (
        .i_clk(clk), .i_nrst(rst_n), .i_rnw(rnw_b), .i_valid(valid_b),
        .o_accept(accept_b), .i_addr(addr_b), .i_data(data_b), .i_be(be_b),
        .o_data(rdata_b), .o_err(err_b), .i_rx(rx_line), .o_tx(tx_b));

    x_top_mem_link #(.p_clk_hz(1000000), .p_baud(100000), .p_timeout(2000)) dut_t (
        .i_clk(clk), .i_nrst(rst_n), .i_rnw(rnw_t), .i_valid(valid_t),
        .o_accept(accept_t), .i_addr(addr_t), .i_data(data_t), .i_be(be_t),
        .o_data(rdata_t), .o_err(err_t), .i_rx(rx_line), .o_tx(tx_t));

    int sel = 0;
    int n_checks = 0;
    int n_fails = 0;
    int acc_a = 0, acc_b = 0, acc_t = 0;

    logic tx_mon, accept_mon;
    assign tx_mon     = (sel == 0) ? tx_a : ((sel == 1) ? tx_b : tx_t);
    assign accept_mon = (sel == 0) ? accept_a : ((sel == 1) ? accept_b : accept_t);

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] exp_data_q[$];
    logic        exp_err_q[$];

    // Completion pulse counters
    always @(negedge clk) begin
        if (accept_a === 1'b1) acc_a <= acc_a + 1;
        if (accept_b === 1'b1) acc_b <= acc_b + 1;
        if (accept_t === 1'b1) acc_t <= acc_t + 1;
    end

    // UART frame decoder for the selected instance's tx line
    initial begin
        logic [7:0] v;
        forever begin
            @(negedge clk);
            if (tx_mon === 1'b0) begin
                repeat (5) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (10) @(negedge clk);
                    v[b] = tx_mon;
                end
                repeat (10) @(negedge clk);
                got_q.push_back(v);
            end
        end
    end

    task automatic send_rx(input logic [7:0] b);
        rx_line = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (10) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, output bit to);
        int k = 0;
        while (got_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        to = (got_q.size() < n);
    endtask

    task automatic wait_acc(input int limit, output int cyc, output bit to);
        cyc = 0;
        while (accept_mon !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        to = (accept_mon !== 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx_a, tx_b, tx_t} !== 3'b111) begin
            n_fails++; $display("FAIL reset_tx: got %b want 111", {tx_a, tx_b, tx_t});
        end
        n_checks++;
        if ({accept_a, accept_b, accept_t, err_a, err_b, err_t} !== 6'b0) begin
            n_fails++; $display("FAIL reset_flags: got %b want 000000",
                                {accept_a, accept_b, accept_t, err_a, err_b, err_t});
        end
        n_checks++;
        if (rdata_a !== 32'h0 || rdata_b !== 8'h0 || rdata_t !== 32'h0) begin
            n_fails++; $display("FAIL reset_data: got %h/%h/%h want 0", rdata_a, rdata_b, rdata_t);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_read();
        bit to; int cyc; int acc0; logic [7:0] e, g; logic [31:0] ed; logic ee;
        logic [7:0] rx_bytes[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        sel = 0; got_q.delete(); acc0 = acc_a;
        exp_q = '{8'h8F, 8'h78, 8'h56, 8'h34, 8'h12};
        exp_data_q.push_back(32'hDEADBEEF); exp_err_q.push_back(1'b0);
        rnw_a = 1'b1; addr_a = 32'h12345678; be_a = 4'hF; valid_a = 1'b1;
        wait_tx(5, to);
        n_checks++;
        if (to) begin n_fails++; $display("FAIL read_tx_timeout: got %0d bytes want 5", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fails++; $display("FAIL read_tx_byte: got %h want %h", g, e); end
        end
        foreach (rx_bytes[i]) send_rx(rx_bytes[i]);
        wait_acc(500, cyc, to);
        valid_a = 1'b0;
        ed = exp_data_q.pop_front(); ee = exp_err_q.pop_front();
        n_checks++;
        if (to) begin n_fails++; $display("FAIL read_accept: no o_accept within 500 cycles"); end
        n_checks++;
        if (rdata_a !== ed || err_a !== ee) begin
            n_fails++; $display("FAIL read_result: got %h err %b want %h err %b", rdata_a, err_a, ed, ee);
        end
        repeat (50) @(negedge clk);
        n_checks++;
        if (acc_a - acc0 !== 1) begin n_fails++; $display("FAIL read_accept_count: got %0d want 1", acc_a - acc0); end
        n_checks++;
        if (rdata_a !== ed) begin n_fails++; $display("FAIL read_hold: got %h want %h", rdata_a, ed); end
    endtask

    task automatic test_write(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [7:0] ack);
        bit to; int cyc; int acc0; logic [7:0] e, g; logic ee;
        sel = 0; got_q.delete(); acc0 = acc_a;
        exp_q.push_back({4'h0, be});
        for (int i = 0; i < 4; i++) exp_q.push_back(addr[8*i +: 8]);
        for (int i = 0; i < 4; i++) exp_q.push_back(wdata[8*i +: 8]);
        exp_err_q.push_back(ack != 8'hA5);
        rnw_a = 1'b0; addr_a = addr; data_a = wdata; be_a = be; valid_a = 1'b1;
        wait_tx(9, to);
        n_checks++;
        if (to) begin n_fails++; $display("FAIL %s_tx_timeout: got %0d bytes want 9", name, got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fails++; $display("FAIL %s_tx_byte: got %h want %h", name, g, e); end
        end
        exp_q.delete();
        send_rx(ack);
        wait_acc(500, cyc, to);
        valid_a = 1'b0;
        ee = exp_err_q.pop_front();
        n_checks++;
        if (to) begin n_fails++; $display("FAIL %s_accept: no o_accept within 500 cycles", name); end
        n_checks++;
        if (err_a !== ee) begin n_fails++; $display("FAIL %s_err: got %b want %b", name, err_a, ee); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (acc_a - acc0 !== 1) begin n_fails++; $display("FAIL %s_accept_count: got %0d want 1", name, acc_a - acc0); end
    endtask

    task automatic test_timeout();
        bit to; int cyc; int acc0; logic [7:0] e, g;
        sel = 2; got_q.delete(); acc0 = acc_t;
        exp_q = '{8'h8F, 8'h40, 8'h00, 8'h00, 8'h00};
        rnw_t = 1'b1; addr_t = 32'h00000040; be_t = 4'hF; valid_t = 1'b1;
        wait_tx(5, to);
        n_checks++;
        if (to) begin n_fails++; $display("FAIL tmo_tx_timeout: got %0d bytes want 5", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fails++; $display("FAIL tmo_tx_byte: got %h want %h", g, e); end
        end
        send_rx(8'h11);
        send_rx(8'h22);
        wait_acc(3000, cyc, to);
        valid_t = 1'b0;
        n_checks++;
        if (to || cyc < 1990 || cyc > 2010) begin
            n_fails++; $display("FAIL tmo_latency: got %0d cycles want about 2000", cyc);
        end
        n_checks++;
        if (err_t !== 1'b1 || rdata_t !== 32'h0) begin
            n_fails++; $display("FAIL tmo_result: got %h err %b want 00000000 err 1", rdata_t, err_t);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (acc_t - acc0 !== 1) begin n_fails++; $display("FAIL tmo_accept_count: got %0d want 1", acc_t - acc0); end
    endtask

    task automatic test_small();
        bit to; int cyc; logic [7:0] e, g;
        sel = 1; got_q.delete();
        exp_q = '{8'h81, 8'hEF, 8'hBE};
        rnw_b = 1'b1; addr_b = 16'hBEEF; be_b = 1'b1; valid_b = 1'b1;
        wait_tx(3, to);
        repeat (200) @(negedge clk);
        n_checks++;
        if (to || got_q.size() != 3) begin
            n_fails++; $display("FAIL small_tx_count: got %0d bytes want 3", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fails++; $display("FAIL small_tx_byte: got %h want %h", g, e); end
        end
        exp_q.delete();
        send_rx(8'h3C);
        wait_acc(500, cyc, to);
        valid_b = 1'b0;
        n_checks++;
        if (to || rdata_b !== 8'h3C || err_b !== 1'b0) begin
            n_fails++; $display("FAIL small_result: got %h err %b want 3c err 0", rdata_b, err_b);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit to; int acc0;
        sel = 0; got_q.delete(); acc0 = acc_a;
        rnw_a = 1'b0; addr_a = 32'h00000055; data_a = 32'h01020304; be_a = 4'hF; valid_a = 1'b1;
        wait_tx(1, to);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        valid_a = 1'b0;
        n_checks++;
        if (tx_a !== 1'b1 || accept_a !== 1'b0 || err_a !== 1'b0 || rdata_a !== 32'h0) begin
            n_fails++; $display("FAIL midreset_state: got tx %b acc %b err %b data %h want 1 0 0 0",
                                tx_a, accept_a, err_a, rdata_a);
        end
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        n_checks++;
        if (tx_a !== 1'b1 || acc_a !== acc0) begin
            n_fails++; $display("FAIL midreset_idle: got tx %b accepts %0d want 1 0", tx_a, acc_a - acc0);
        end
        got_q.delete();
        test_write("after_reset", 32'h00000020, 32'h89ABCDEF, 4'hF, 8'hA5);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write("write", 32'h00000010, 32'hCAFEF00D, 4'h3, 8'hA5);
        test_write("nack", 32'h00000010, 32'h12345678, 4'hF, 8'h5A);
        test_timeout();
        test_small();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
